// File: rtl/idu_16bit_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : idu_16bit_serial_if
// Description : Handshake and data bundle between the CPU sequencer (master)
//               and the serial increment/decrement unit (slave).
//               i_Start/i_Value/i_Decrement : request and operand
//               i_Ack                       : consumer took o_Result
//               o_Busy/o_Valid              : unit status
//               o_Result/o_Wrap             : result and 16-bit wrap indicator
//               o_Oam_Bug                   : only when IDU_OAM_BUG_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
interface idu_16bit_serial_if #(
    parameter int DATA_W = 16
);
    logic              i_Start;
    logic [DATA_W-1:0] i_Value;
    logic              i_Decrement;
    logic              i_Ack;
    logic              o_Busy;
    logic              o_Valid;
    logic [DATA_W-1:0] o_Result;
    logic              o_Wrap;
`ifdef IDU_OAM_BUG_EN
    logic              o_Oam_Bug;

    modport slave (
        input  i_Start, i_Value, i_Decrement, i_Ack,
        output o_Busy, o_Valid, o_Result, o_Wrap, o_Oam_Bug
    );
    modport master (
        output i_Start, i_Value, i_Decrement, i_Ack,
        input  o_Busy, o_Valid, o_Result, o_Wrap, o_Oam_Bug
    );
`else
    modport slave (
        input  i_Start, i_Value, i_Decrement, i_Ack,
        output o_Busy, o_Valid, o_Result, o_Wrap
    );
    modport master (
        output i_Start, i_Value, i_Decrement, i_Ack,
        input  o_Busy, o_Valid, o_Result, o_Wrap
    );
`endif
endinterface
`default_nettype wire

// File: rtl/idu_16bit_serial.sv
`default_nettype none
// ============================================================================
// Module      : idu_16bit_serial
// Description : Sequential increment/decrement unit for register pairs, SP
//               and PC. One DATA_W/2-bit adder slice is used twice: the low
//               half first, then the high half (skipped when SKIP_HIGH=1 and
//               nothing propagates). Flags are never produced.
// Ports       : i_Clk      - clock, rising edge
//               i_Reset_n  - asynchronous active-low reset
//               bus        - idu_16bit_serial_if.slave (start/valid/ack
//                            handshake, operand, result, wrap)
// Options     : define IDU_OAM_BUG_EN to add o_Oam_Bug, flagging operands in
//               the 0xFE00-0xFEFF OAM range (DMG OAM-corruption model).
// Parameters  : DATA_W must be even; SKIP_HIGH selects the short path.
// Revision    : 1.0 - initial release
// ============================================================================
module idu_16bit_serial #(
    parameter int DATA_W    = 16,
    parameter bit SKIP_HIGH = 1'b1
) (
    input  wire logic          i_Clk,
    input  wire logic          i_Reset_n,
    idu_16bit_serial_if.slave  bus
);
    localparam int HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_capture;

    logic [HALF_W-1:0]   r_val_lo;
    logic [HALF_W-1:0]   r_val_hi;
    logic [HALF_W-1:0]   r_low;
    logic                r_dec;
    logic                r_cy;
    logic [DATA_W-1:0]   r_result;
    logic                r_wrap;

    logic [HALF_W-1:0]   w_add_a;
    logic [HALF_W-1:0]   w_add_b;
    logic [HALF_W:0]     w_sum;
    logic                w_prop;

    // Shared adder slice. Decrement adds all-ones (i.e. -1); carry-out XOR
    // the mode bit turns the raw carry into "carry" for increment and
    // "borrow" for decrement. In HIGH the addend is the propagated cy,
    // sign-extended for decrement.
    always_comb begin
        w_add_a = r_val_lo;
        w_add_b = r_dec ? {HALF_W{1'b1}} : HALF_W'(1);
        if (r_state == ST_HIGH) begin
            w_add_a = r_val_hi;
            w_add_b = r_dec ? {HALF_W{r_cy}} : HALF_W'(r_cy);
        end
        w_sum  = {1'b0, w_add_a} + {1'b0, w_add_b};
        w_prop = w_sum[HALF_W] ^ r_dec;
    end

    // Next-state logic. A new operand is accepted only in IDLE, or in DONE
    // together with i_Ack (zero-bubble back-to-back).
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_LOW;
                end
            end
            ST_LOW: begin
                if (SKIP_HIGH && !w_prop) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.i_Ack) begin
                    if (bus.i_Start) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_LOW;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state  <= ST_IDLE;
            r_val_lo <= '0;
            r_val_hi <= '0;
            r_low    <= '0;
            r_dec    <= 1'b0;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_val_lo <= bus.i_Value[HALF_W-1:0];
                r_val_hi <= bus.i_Value[DATA_W-1:HALF_W];
                r_dec    <= bus.i_Decrement;
            end
            case (r_state)
                ST_LOW: begin
                    r_low <= w_sum[HALF_W-1:0];
                    r_cy  <= w_prop;
                    if (SKIP_HIGH && !w_prop) begin
                        r_result <= {r_val_hi, w_sum[HALF_W-1:0]};
                        r_wrap   <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    r_result <= {w_sum[HALF_W-1:0], r_low};
                    // The high half itself propagated only if cy was set and
                    // Vhi sat at all-ones (inc) or zero (dec).
                    r_wrap   <= r_cy & w_prop;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_Busy   = (r_state != ST_IDLE);
    assign bus.o_Valid  = (r_state == ST_DONE);
    assign bus.o_Result = r_result;
    assign bus.o_Wrap   = r_wrap;

`ifdef IDU_OAM_BUG_EN
    logic r_oam_bug;

    // Captured with the operand, held through DONE, dropped on return to IDLE.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_oam_bug <= 1'b0;
        end else if (w_capture) begin
            r_oam_bug <= (bus.i_Value[DATA_W-1 -: 8] == 8'hFE);
        end else if ((r_state == ST_DONE) && bus.i_Ack) begin
            r_oam_bug <= 1'b0;
        end
    end

    assign bus.o_Oam_Bug = r_oam_bug;
`endif
endmodule
`default_nettype wire

// File: tb/tb_idu_16bit_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_idu_16bit_serial
// Description : Directed scoreboard bench for idu_16bit_serial. Stimulus
//               pushes hand-computed expectations; a monitor pops them on
//               each rising o_Valid and checks result, wrap, latency and
//               (with IDU_OAM_BUG_EN) the OAM flag, plus hold stability.
//               A second instance with SKIP_HIGH=0 checks the long path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idu_16bit_serial;
    localparam int DATA_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idu_16bit_serial_if #(.DATA_W(DATA_W)) bus ();
    idu_16bit_serial_if #(.DATA_W(DATA_W)) bus_ns ();

    idu_16bit_serial #(.DATA_W(DATA_W), .SKIP_HIGH(1'b1)) u_dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus.slave)
    );

    idu_16bit_serial #(.DATA_W(DATA_W), .SKIP_HIGH(1'b0)) u_dut_ns (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus_ns.slave)
    );

    typedef struct {
        logic [15:0] result;
        logic        wrap;
        logic        oam;
        int          lat;
        int          t_start;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one pop per transaction, then stability checks while held.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.o_Valid && !prev_valid) begin
                check("valid_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    check("result", bus.o_Result, cur.result);
                    check("wrap", bus.o_Wrap, cur.wrap);
                    check("latency", cyc - cur.t_start + 1, cur.lat);
                    check("busy_in_done", bus.o_Busy, 1);
`ifdef IDU_OAM_BUG_EN
                    check("oam_bug", bus.o_Oam_Bug, cur.oam);
`endif
                end
            end else if (bus.o_Valid) begin
                check("hold_result", bus.o_Result, cur.result);
                check("hold_wrap", bus.o_Wrap, cur.wrap);
            end
            prev_valid = bus.o_Valid;
        end
    end

    task automatic push_exp(input logic [15:0] res, input logic wrap, input logic oam, input int lat);
        exp_t e;
        e.result  = res;
        e.wrap    = wrap;
        e.oam     = oam;
        e.lat     = lat;
        e.t_start = cyc + 1;   // the next rising edge samples i_Start
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [15:0] val, input logic dec,
                            input logic [15:0] res, input logic wrap,
                            input logic oam, input int lat);
        @(negedge clk);
        bus.i_Start     = 1'b1;
        bus.i_Value     = val;
        bus.i_Decrement = dec;
        push_exp(res, wrap, oam, lat);
        @(negedge clk);
        bus.i_Start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.o_Valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("valid_within_bound", bus.o_Valid, 1);
    endtask

    task automatic ack_once();
        bus.i_Ack = 1'b1;
        @(negedge clk);
        bus.i_Ack = 1'b0;
    endtask

    task automatic op(input logic [15:0] val, input logic dec,
                      input logic [15:0] res, input logic wrap,
                      input logic oam, input int lat);
        start_op(val, dec, res, wrap, oam, lat);
        wait_valid();
        if (bus.o_Valid) ack_once();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, bus.o_Busy, 0);
        check({tag, "_valid"}, bus.o_Valid, 0);
        check({tag, "_result"}, bus.o_Result, 0);
        check({tag, "_wrap"}, bus.o_Wrap, 0);
`ifdef IDU_OAM_BUG_EN
        check({tag, "_oam"}, bus.o_Oam_Bug, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bus.i_Start = 1'b0; bus.i_Value = '0; bus.i_Decrement = 1'b0; bus.i_Ack = 1'b0;
        bus_ns.i_Start = 1'b0; bus_ns.i_Value = '0; bus_ns.i_Decrement = 1'b0; bus_ns.i_Ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // SKIP_HIGH=0: no-carry increment still takes the HIGH phase
        bus_ns.i_Start = 1'b1; bus_ns.i_Value = 16'h1234; bus_ns.i_Decrement = 1'b0;
        @(negedge clk);
        bus_ns.i_Start = 1'b0;
        lat = 1;
        while (!bus_ns.o_Valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("noskip_latency", lat, 3);
        check("noskip_result", bus_ns.o_Result, 16'h1235);
        check("noskip_wrap", bus_ns.o_Wrap, 0);
        bus_ns.i_Ack = 1'b1;
        @(negedge clk);
        bus_ns.i_Ack = 1'b0;

        // Directed vectors on the SKIP_HIGH=1 unit
        op(16'h1234, 1'b0, 16'h1235, 1'b0, 1'b0, 2);
        op(16'h12FF, 1'b0, 16'h1300, 1'b0, 1'b0, 3);
        op(16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 3);
        op(16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 3);
        op(16'h1200, 1'b1, 16'h11FF, 1'b0, 1'b0, 3);
        op(16'h5678, 1'b1, 16'h5677, 1'b0, 1'b0, 2);
        op(16'hFE10, 1'b0, 16'hFE11, 1'b0, 1'b1, 2);
        op(16'hFD10, 1'b0, 16'hFD11, 1'b0, 1'b0, 2);

        // Back-pressure: held result, ignored start, then ack+start back-to-back
        start_op(16'hABFF, 1'b0, 16'hAC00, 1'b0, 1'b0, 3);
        wait_valid();
        bus.i_Start = 1'b1; bus.i_Value = 16'h7777; bus.i_Decrement = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("backpressure_valid", bus.o_Valid, 1);
        end
        bus.i_Value = 16'h00FF; bus.i_Decrement = 1'b0; bus.i_Ack = 1'b1;
        push_exp(16'h0100, 1'b0, 1'b0, 3);
        @(negedge clk);
        bus.i_Start = 1'b0; bus.i_Ack = 1'b0;
        check("b2b_no_idle_busy", bus.o_Busy, 1);
        check("b2b_low_valid", bus.o_Valid, 0);
        wait_valid();
        if (bus.o_Valid) ack_once();

        // Reset while in HIGH aborts the operation
        @(negedge clk);
        bus.i_Start = 1'b1; bus.i_Value = 16'h12FF; bus.i_Decrement = 1'b0;
        @(negedge clk);
        bus.i_Start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", bus.o_Busy, 1);
        rst_n = 1'b0;
        #1;
        check_cleared("midop_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_no_valid", bus.o_Valid, 0);
        end

        // Recovery after reset
        op(16'h1234, 1'b0, 16'h1235, 1'b0, 1'b0, 2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
